// File: rtl/mae_pkg.sv
// Shared widths, signed datapath types and helpers for the MAE DSP tile model.
package mae_pkg;

  localparam int unsigned MAE_A_W    = 18;
  localparam int unsigned MAE_B_W    = 18;
  localparam int unsigned MAE_PROD_W = 36;
  localparam int unsigned MAE_P_W    = 40;

  typedef logic signed [MAE_A_W-1:0]    mae_a_t;
  typedef logic signed [MAE_B_W-1:0]    mae_b_t;
  typedef logic signed [MAE_PROD_W-1:0] mae_prod_t;
  typedef logic signed [MAE_P_W-1:0]    mae_p_t;

  // Sign-extend the 36-bit product onto the 40-bit accumulator width.
  function automatic mae_p_t sext_prod(input mae_prod_t m);
    return {{(MAE_P_W-MAE_PROD_W){m[MAE_PROD_W-1]}}, m};
  endfunction

endpackage

// File: rtl/mae_en_reg.sv
// Optional pipeline register with sync reset, sync clear and load enable.
// With PRESENT=0 it collapses to a wire from d to q.
module mae_en_reg #(
  parameter int unsigned W       = 8,
  parameter bit          PRESENT = 1'b1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (PRESENT) begin : g_reg
    logic [W-1:0] q_r;

    // Priority: reset, then clear, then load.
    always_ff @(posedge clk) begin
      if (srst) begin
        q_r <= '0;
      end else if (clr) begin
        q_r <= '0;
      end else if (en) begin
        q_r <= d;
      end
    end

    assign q = q_r;
  end else begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, srst, clr, en};
    assign q = d;
  end

endmodule

// File: rtl/mae_dsp_model.sv
// Cycle-accurate model of the MAE DSP tile: signed 18x18 multiply, optional
// pipeline stages, post-adder with static C or registered-P feedback (MACC).
module mae_dsp_model
  import mae_pkg::*;
#(
  parameter bit A_REG        = 1'b0,
  parameter bit B_REG        = 1'b0,
  parameter bit C_REG        = 1'b0,
  parameter bit MULT_REG     = 1'b0,
  parameter bit P_REG        = 1'b0,
  parameter bit POST_ADD     = 1'b0,
  parameter bit USE_FEEDBACK = 1'b0
) (
  input  logic   CLK,
  input  logic   SRST,
  input  mae_a_t A,
  input  logic   A_EN,
  input  logic   A_CLR,
  input  mae_b_t B,
  input  logic   B_EN,
  input  logic   B_CLR,
  input  mae_p_t C,
  input  logic   C_EN,
  input  logic   C_CLR,
  input  logic   CDIN_FDBK_SEL,
  input  logic   P_EN,
  input  logic   P_CLR,
  output mae_p_t P,
  output logic   OVF
);

  if (USE_FEEDBACK && (!P_REG || !POST_ADD)) begin : g_bad_cfg
    $fatal(1, "mae_dsp_model: USE_FEEDBACK requires P_REG=1 and POST_ADD=1");
  end

  mae_a_t    a_q;
  mae_b_t    b_q;
  mae_p_t    c_q;
  mae_prod_t prod;
  mae_prod_t m_q;
  mae_p_t    m40;
  mae_p_t    op;
  mae_p_t    sum;
  mae_p_t    p_q;
  logic      ovf_c;

  mae_en_reg #(.W(MAE_A_W), .PRESENT(A_REG)) u_a_reg (
    .clk(CLK), .srst(SRST), .clr(A_CLR), .en(A_EN), .d(A), .q(a_q)
  );

  mae_en_reg #(.W(MAE_B_W), .PRESENT(B_REG)) u_b_reg (
    .clk(CLK), .srst(SRST), .clr(B_CLR), .en(B_EN), .d(B), .q(b_q)
  );

  mae_en_reg #(.W(MAE_P_W), .PRESENT(C_REG)) u_c_reg (
    .clk(CLK), .srst(SRST), .clr(C_CLR), .en(C_EN), .d(C), .q(c_q)
  );

  // Operands widened first so the 36-bit multiply is exact for all inputs.
  assign prod = mae_prod_t'(a_q) * mae_prod_t'(b_q);

  // Product stage has no enable or clear: it reloads every cycle.
  mae_en_reg #(.W(MAE_PROD_W), .PRESENT(MULT_REG)) u_m_reg (
    .clk(CLK), .srst(SRST), .clr(1'b0), .en(1'b1), .d(prod), .q(m_q)
  );

  assign m40 = sext_prod(m_q);

  if (USE_FEEDBACK) begin : g_fdbk
    assign op = CDIN_FDBK_SEL ? p_q : c_q;
  end else begin : g_no_fdbk
    logic unused_sel;
    assign unused_sel = CDIN_FDBK_SEL;
    assign op = c_q;
  end

  assign sum   = POST_ADD ? mae_p_t'(m40 + op) : m40;
  assign ovf_c = POST_ADD && (m40[MAE_P_W-1] == op[MAE_P_W-1])
                          && (sum[MAE_P_W-1] != m40[MAE_P_W-1]);

  mae_en_reg #(.W(MAE_P_W), .PRESENT(P_REG)) u_p_reg (
    .clk(CLK), .srst(SRST), .clr(P_CLR), .en(P_EN), .d(sum), .q(p_q)
  );

  assign P = p_q;

  // Overflow is sticky across P loads when P is registered, live otherwise.
  if (P_REG) begin : g_ovf_reg
    logic ovf_q;

    always_ff @(posedge CLK) begin
      if (SRST) begin
        ovf_q <= 1'b0;
      end else if (P_CLR) begin
        ovf_q <= 1'b0;
      end else if (P_EN) begin
        ovf_q <= ovf_q | ovf_c;
      end
    end

    assign OVF = ovf_q;
  end else begin : g_ovf_comb
    assign OVF = ovf_c;
  end

endmodule

// File: tb/tb_mae_dsp_model.sv
// Directed bench for mae_dsp_model: combinational vector table plus
// multi-cycle sequences on pipelined, C-registered and MACC configurations.
module tb_mae_dsp_model;
  import mae_pkg::*;

  logic   clk = 1'b0;
  logic   srst;
  mae_a_t a;
  mae_b_t b;
  mae_p_t c;
  logic   a_en, a_clr, b_en, b_clr, c_en, c_clr, sel, p_en, p_clr;

  mae_p_t p_comb, p_pipe, p_cadd, p_macc;
  logic   ovf_comb, ovf_pipe, ovf_cadd, ovf_macc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mae_dsp_model #(.POST_ADD(1'b1)) u_comb (
    .CLK(clk), .SRST(srst), .A(a), .A_EN(a_en), .A_CLR(a_clr),
    .B(b), .B_EN(b_en), .B_CLR(b_clr), .C(c), .C_EN(c_en), .C_CLR(c_clr),
    .CDIN_FDBK_SEL(sel), .P_EN(p_en), .P_CLR(p_clr), .P(p_comb), .OVF(ovf_comb)
  );

  mae_dsp_model #(.A_REG(1'b1), .B_REG(1'b1), .C_REG(1'b1), .MULT_REG(1'b1),
                  .P_REG(1'b1)) u_pipe (
    .CLK(clk), .SRST(srst), .A(a), .A_EN(a_en), .A_CLR(a_clr),
    .B(b), .B_EN(b_en), .B_CLR(b_clr), .C(c), .C_EN(c_en), .C_CLR(c_clr),
    .CDIN_FDBK_SEL(sel), .P_EN(p_en), .P_CLR(p_clr), .P(p_pipe), .OVF(ovf_pipe)
  );

  mae_dsp_model #(.C_REG(1'b1), .P_REG(1'b1), .POST_ADD(1'b1)) u_cadd (
    .CLK(clk), .SRST(srst), .A(a), .A_EN(a_en), .A_CLR(a_clr),
    .B(b), .B_EN(b_en), .B_CLR(b_clr), .C(c), .C_EN(c_en), .C_CLR(c_clr),
    .CDIN_FDBK_SEL(sel), .P_EN(p_en), .P_CLR(p_clr), .P(p_cadd), .OVF(ovf_cadd)
  );

  mae_dsp_model #(.P_REG(1'b1), .POST_ADD(1'b1), .USE_FEEDBACK(1'b1)) u_macc (
    .CLK(clk), .SRST(srst), .A(a), .A_EN(a_en), .A_CLR(a_clr),
    .B(b), .B_EN(b_en), .B_CLR(b_clr), .C(c), .C_EN(c_en), .C_CLR(c_clr),
    .CDIN_FDBK_SEL(sel), .P_EN(p_en), .P_CLR(p_clr), .P(p_macc), .OVF(ovf_macc)
  );

  typedef struct {
    mae_a_t a;
    mae_b_t b;
    mae_p_t c;
    mae_p_t p;
    logic   ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then accumulate 2^34 per cycle until the signed 40-bit result wraps.
  task automatic run_ovf();
    srst = 1'b1; p_clr = 1'b0; p_en = 1'b1; sel = 1'b1;
    a = 18'h20000; b = 18'h20000;
    tick();
    srst = 1'b0;
    chk("ovf_start_p", p_macc, 40'h0);
    for (int k = 1; k <= 31; k++) tick();
    chk("acc31_p", p_macc, 40'h7C_0000_0000);
    chk("acc31_ovf", {39'b0, ovf_macc}, 40'h0);
    tick();
    chk("wrap_p", p_macc, 40'h80_0000_0000);
    chk("wrap_ovf", {39'b0, ovf_macc}, 40'h1);
    tick();
    chk("post_wrap_p", p_macc, 40'h84_0000_0000);
    chk("sticky_ovf", {39'b0, ovf_macc}, 40'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; a = '0; b = '0; c = '0;
    a_en = 1'b1; a_clr = 1'b0; b_en = 1'b1; b_clr = 1'b0;
    c_en = 1'b1; c_clr = 1'b0; sel = 1'b0; p_en = 1'b1; p_clr = 1'b0;

    // Combinational P = A*B + C with live overflow.
    vecs[0] = '{18'sd3,      -18'sd5,     40'sd0,           -40'sd15,           1'b0};
    vecs[1] = '{18'sd100,    18'sd200,    40'sd7,           40'sd20007,         1'b0};
    vecs[2] = '{18'h20000,   18'h20000,   40'sd0,           40'h04_0000_0000,   1'b0};
    vecs[3] = '{18'h20000,   18'sd131071, 40'sd0,           -40'sd17179738112,  1'b0};
    vecs[4] = '{18'sd131071, 18'sd131071, 40'sd0,           40'sd17179607041,   1'b0};
    vecs[5] = '{18'sd1,      18'sd1,      40'h7F_FFFF_FFFF, 40'h80_0000_0000,   1'b1};
    vecs[6] = '{-18'sd1,     18'sd1,      40'h80_0000_0000, 40'h7F_FFFF_FFFF,   1'b1};
    vecs[7] = '{18'sd1,      -18'sd1,     40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFE,   1'b0};
    vecs[8] = '{18'sd0,      18'sd12345,  -40'sd7,          -40'sd7,            1'b0};
    vecs[9] = '{-18'sd2,     18'sd3,      40'sd6,           40'sd0,             1'b0};

    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
      #1;
      chk($sformatf("comb_p[%0d]", i), p_comb, vecs[i].p);
      chk($sformatf("comb_ovf[%0d]", i), {39'b0, ovf_comb}, {39'b0, vecs[i].ovf});
    end

    // Fully pipelined multiply: A/B to P takes three edges.
    a = '0; b = '0; c = '0;
    tick();
    chk("pipe_rst_p", p_pipe, 40'h0);
    srst = 1'b0; a = 18'sd3; b = -18'sd5;
    tick();
    chk("pipe_lat1", p_pipe, 40'h0);
    tick();
    chk("pipe_lat2", p_pipe, 40'h0);
    tick();
    chk("pipe_lat3", p_pipe, -40'sd15);

    // Registered C plus registered P; C_CLR pulse drops the addend once.
    srst = 1'b1;
    tick();
    srst = 1'b0; a = 18'sd100; b = 18'sd200; c = 40'sd7;
    tick();
    chk("cadd_c_lat", p_cadd, 40'sd20000);
    tick();
    chk("cadd_sum", p_cadd, 40'sd20007);
    c_clr = 1'b1;
    tick();
    chk("cadd_clr_edge", p_cadd, 40'sd20007);
    c_clr = 1'b0;
    tick();
    chk("cadd_after_clr", p_cadd, 40'sd20000);
    tick();
    chk("cadd_reload", p_cadd, 40'sd20007);

    // MACC: restart with C, then accumulate 6 per cycle.
    srst = 1'b1;
    tick();
    srst = 1'b0; a = 18'sd2; b = 18'sd3; c = 40'sd10; sel = 1'b0;
    tick();
    chk("macc_restart", p_macc, 40'sd16);
    sel = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("macc_acc[%0d]", i), p_macc, mae_p_t'(16 + 6 * i));
    end
    p_en = 1'b0;
    tick();
    chk("macc_hold1", p_macc, 40'sd40);
    tick();
    chk("macc_hold2", p_macc, 40'sd40);
    p_en = 1'b1;
    tick();
    chk("macc_resume", p_macc, 40'sd46);

    // Overflow then P_CLR, with P_EN still high: clear wins.
    run_ovf();
    p_clr = 1'b1;
    tick();
    chk("pclr_p", p_macc, 40'h0);
    chk("pclr_ovf", {39'b0, ovf_macc}, 40'h0);
    p_clr = 1'b0;
    tick();
    chk("pclr_restart", p_macc, 40'h04_0000_0000);

    // Overflow, hold with P_EN low, then SRST mid-accumulation.
    run_ovf();
    p_en = 1'b0;
    tick();
    tick();
    chk("hold_ovf_p", p_macc, 40'h84_0000_0000);
    chk("hold_ovf_flag", {39'b0, ovf_macc}, 40'h1);
    p_en = 1'b1; a = 18'sd2; b = 18'sd3; srst = 1'b1;
    tick();
    chk("srst_macc_p", p_macc, 40'h0);
    chk("srst_macc_ovf", {39'b0, ovf_macc}, 40'h0);
    chk("srst_pipe_p", p_pipe, 40'h0);
    srst = 1'b0;
    tick();
    chk("srst_after_macc", p_macc, 40'sd6);
    chk("srst_after_pipe", p_pipe, 40'h0);
    tick();
    chk("srst_acc2", p_macc, 40'sd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
